// File: rtl/aes_pkg.sv
// AES-128 shared definitions: sizes, sequencer FSM encoding and GF(2^8) helpers.
// The helpers build the S-box arithmetically (inverse + affine map), so no table ROM is kept.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_BLK_W = 128;
   localparam int AES_RC_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_fsm_e;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply, shift-and-add
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   // Round constant for key expansion; entries past round 10 continue the x^(i-1) sequence
   function automatic logic [7:0] rcon(input logic [AES_RC_W-1:0] rc);
      logic [7:0] v;
      case (rc)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         4'd11:   v = 8'h6c;
         4'd12:   v = 8'hd8;
         4'd13:   v = 8'hab;
         4'd14:   v = 8'h4d;
         4'd15:   v = 8'h9a;
         default: v = 8'h8d;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rounds.sv
// Combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey with the next round key, which is expanded here from keyin and rc.
// Byte 0 of every 128-bit vector sits at [127:120]; state is column-major (byte i = row i%4, col i/4).
module rounds
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] data,
   input  logic [AES_BLK_W-1:0] keyin,
   input  logic [AES_RC_W-1:0]  rc,
   input  logic                 indx,
   output logic [AES_BLK_W-1:0] state_out,
   output logic [AES_BLK_W-1:0] keyout
);

   logic [7:0]  din [16];
   logic [7:0]  sr  [16];
   logic [7:0]  mc  [16];
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] nw0, nw1, nw2, nw3;
   logic [31:0] sub_rot;

   // Next round key: one AES-128 key-expansion step
   always_comb begin
      w0      = keyin[127:96];
      w1      = keyin[95:64];
      w2      = keyin[63:32];
      w3      = keyin[31:0];
      sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                ^ {rcon(rc), 24'h000000};
      nw0     = w0 ^ sub_rot;
      nw1     = w1 ^ nw0;
      nw2     = w2 ^ nw1;
      nw3     = w3 ^ nw2;
      keyout  = {nw0, nw1, nw2, nw3};
   end

   // SubBytes + ShiftRows (row r rotates left by r columns), then MixColumns per column
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         din[i] = data[127-8*i -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[c*4+r] = sbox(din[((c+r)%4)*4+r]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[c*4+0] = xtime(sr[c*4+0]) ^ xtime(sr[c*4+1]) ^ sr[c*4+1] ^ sr[c*4+2] ^ sr[c*4+3];
         mc[c*4+1] = sr[c*4+0] ^ xtime(sr[c*4+1]) ^ xtime(sr[c*4+2]) ^ sr[c*4+2] ^ sr[c*4+3];
         mc[c*4+2] = sr[c*4+0] ^ sr[c*4+1] ^ xtime(sr[c*4+2]) ^ xtime(sr[c*4+3]) ^ sr[c*4+3];
         mc[c*4+3] = xtime(sr[c*4+0]) ^ sr[c*4+0] ^ sr[c*4+1] ^ sr[c*4+2] ^ xtime(sr[c*4+3]);
      end
   end

   // AddRoundKey; the final round skips MixColumns
   always_comb begin
      state_out = '0;
      for (int i = 0; i < 16; i++) begin
         state_out[127-8*i -: 8] = (indx ? sr[i] : mc[i]) ^ keyout[127-8*i -: 8];
      end
   end

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption sequencer around the combinational rounds stage.
// One block in flight: accept, NR round edges, one cycle to raise out_valid, then output handshake.
// Optional debug taps (round, state, final round key) when AES_ROUND_TAP_EN is defined.
module aes128_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] plaintext,
   input  logic [AES_BLK_W-1:0] key,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] ciphertext
`ifdef AES_ROUND_TAP_EN
   ,
   output logic [AES_RC_W-1:0]  dbg_round,
   output logic [AES_BLK_W-1:0] dbg_state,
   output logic [AES_BLK_W-1:0] dbg_last_key
`endif
);

   localparam logic [AES_RC_W-1:0] NR_RC = AES_RC_W'(NR);

   aes_fsm_e             fsm;
   logic [AES_BLK_W-1:0] state_q;
   logic [AES_BLK_W-1:0] key_q;
   logic [AES_RC_W-1:0]  rnd;
   logic [AES_BLK_W-1:0] round_state;
   logic [AES_BLK_W-1:0] round_key;
   logic                 last_rnd;

`ifdef AES_ROUND_TAP_EN
   logic [AES_BLK_W-1:0] last_key_q;
`endif

   assign last_rnd = (rnd == NR_RC);

   rounds u_round (
      .data      (state_q),
      .keyin     (key_q),
      .rc        (rnd),
      .indx      (last_rnd),
      .state_out (round_state),
      .keyout    (round_key)
   );

   // Sequencer FSM with registered handshake outputs and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm        <= IDLE;
         rnd        <= '0;
         state_q    <= '0;
         key_q      <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         ciphertext <= '0;
`ifdef AES_ROUND_TAP_EN
         last_key_q <= '0;
`endif
      end else begin
         case (fsm)
            IDLE: begin
               // in_ready is always high here, so in_valid alone completes the handshake
               if (in_valid) begin
                  state_q  <= plaintext ^ key;
                  key_q    <= key;
                  rnd      <= 4'd1;
                  in_ready <= 1'b0;
                  fsm      <= RUN;
               end
            end
            RUN: begin
               state_q <= round_state;
               key_q   <= round_key;
               if (last_rnd) begin
                  ciphertext <= round_state;
`ifdef AES_ROUND_TAP_EN
                  last_key_q <= round_key;
`endif
                  rnd        <= '0;
                  fsm        <= DONE;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: begin
               // First DONE cycle raises out_valid; the handshake needs it already high
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: begin
               fsm       <= IDLE;
               rnd       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef AES_ROUND_TAP_EN
   assign dbg_round    = rnd;
   assign dbg_state    = state_q;
   assign dbg_last_key = last_key_q;
`endif

endmodule
